// File: rtl/yd_irq_if.sv
// Core-side handshake and data-bus bundle for the yd_irq_ctrl interrupt controller.
// master = core / bus host, slave = interrupt controller.
interface yd_irq_if;
   logic [15:0] bus_addr;
   logic [15:0] bus_din;
   logic        bus_we;
   logic [15:0] bus_dout;
   logic        int_vld;
   logic        int_rdy;

   modport master (
      output bus_addr, bus_din, bus_we, int_rdy,
      input  bus_dout, int_vld
   );

   modport slave (
      input  bus_addr, bus_din, bus_we, int_rdy,
      output bus_dout, int_vld
   );
endinterface

// File: rtl/yd_irq_ctrl.sv
// Level-source interrupt controller with a 4-word register window (CTRL/MASK/PEND/ID).
// Define YD_IRQ_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module yd_irq_ctrl #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int          NSRC      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NSRC-1:0] irq_src,
   yd_irq_if.slave         bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, SERVICE} state_t;

   state_t          state_reg, state_next;
   logic            gen_reg;
   logic [NSRC-1:0] mask_reg;
   logic [NSRC-1:0] pend_reg, pend_next;
   logic [NSRC-1:0] irq_prev_reg;
   logic            armed_reg;
   logic            id_active_reg;
   logic [2:0]      id_src_reg;
   logic [15:0]     dout_reg;

   logic [15:0]     offset;
   logic            hit;
   logic            wr_ctrl, wr_mask, wr_pend, wr_id;
   logic            eoi;
   logic            dispatch;
   logic            int_vld;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] req;
   logic            req_any;
   logic [2:0]      win;
   logic [15:0]     rd_data;

   // Window decode by subtraction so BASE_ADDR needs no alignment.
   assign offset  = bus.bus_addr - BASE_ADDR;
   assign hit     = (offset < 16'd4);
   assign wr_ctrl = bus.bus_we && hit && (offset[1:0] == 2'd0);
   assign wr_mask = bus.bus_we && hit && (offset[1:0] == 2'd1);
   assign wr_pend = bus.bus_we && hit && (offset[1:0] == 2'd2);
   assign wr_id   = bus.bus_we && hit && (offset[1:0] == 2'd3);
   assign eoi     = wr_id && (state_reg == SERVICE);

   assign req     = pend_reg & mask_reg;
   assign req_any = gen_reg && (|req);

`ifdef YD_IRQ_RR_EN
   localparam logic [3:0] NSRC_W   = 4'(NSRC);
   localparam logic [2:0] LAST_IDX = 3'(NSRC - 1);

   logic [2:0] rr_start_reg;
   logic [3:0] rr_idx;
   logic       rr_found;

   // Rotating search beginning one past the last dispatched source.
   always_comb begin
      win      = '0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 0; k < NSRC; k++) begin
         rr_idx = {1'b0, rr_start_reg} + 4'(k);
         if (rr_idx >= NSRC_W) begin
            rr_idx = rr_idx - NSRC_W;
         end
         if (!rr_found && req[rr_idx[2:0]]) begin
            win      = rr_idx[2:0];
            rr_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_start_reg <= '0;
      end else if (dispatch) begin
         rr_start_reg <= (win == LAST_IDX) ? 3'd0 : win + 3'd1;
      end
   end
`else
   always_comb begin
      win = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            win = 3'(i);
         end
      end
   end
`endif

   // Set beats both the W1C and the dispatch clear of the same bit.
   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign rise[gi]      = armed_reg & irq_src[gi] & ~irq_prev_reg[gi];
      assign pend_next[gi] = rise[gi]
                           | (pend_reg[gi]
                              & ~(wr_pend & bus.bus_din[gi])
                              & ~(dispatch && (win == 3'(gi))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req_any && bus.int_rdy) state_next = ISSUE;
         ISSUE:   state_next = SERVICE;
         SERVICE: if (eoi) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      int_vld  = (state_reg == ISSUE);
      dispatch = (state_reg == IDLE) && (state_next == ISSUE);
   end

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (offset[1:0])
            2'd0: rd_data[0]      = gen_reg;
            2'd1: rd_data[NSRC-1:0] = mask_reg;
            2'd2: rd_data[NSRC-1:0] = pend_reg;
            default: begin
               rd_data[15]  = id_active_reg;
               rd_data[2:0] = id_src_reg;
            end
         endcase
      end
   end

   // armed_reg masks the first cycle after reset so sources already high are not seen as edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_reg       <= 1'b0;
         mask_reg      <= '0;
         pend_reg      <= '0;
         irq_prev_reg  <= '0;
         armed_reg     <= 1'b0;
         id_active_reg <= 1'b0;
         id_src_reg    <= '0;
         dout_reg      <= '0;
      end else begin
         irq_prev_reg <= irq_src;
         armed_reg    <= 1'b1;
         pend_reg     <= pend_next;
         dout_reg     <= rd_data;
         if (wr_ctrl) gen_reg  <= bus.bus_din[0];
         if (wr_mask) mask_reg <= bus.bus_din[NSRC-1:0];
         if (dispatch) begin
            id_active_reg <= 1'b1;
            id_src_reg    <= win;
         end else if (eoi) begin
            id_active_reg <= 1'b0;
         end
      end
   end

   assign bus.bus_dout = dout_reg;
   assign bus.int_vld  = int_vld;

endmodule

// File: tb/tb_yd_irq_ctrl.sv
// Self-checking bench for yd_irq_ctrl: directed scenarios plus random traffic against a reference model.
module tb_yd_irq_ctrl;

   localparam logic [15:0] BASE = 16'hFF00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irq_src;

   yd_irq_if bus ();

   yd_irq_ctrl #(.BASE_ADDR(BASE), .NSRC(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .irq_src (irq_src),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: phase 0 = idle, 1 = interrupt being issued, 2 = in service.
   bit [7:0]    m_prev, m_pend, m_mask;
   bit          m_gen, m_armed, m_active, m_vld;
   int          m_phase, m_src, m_start;
   logic [15:0] m_dout;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_prev = 0; m_pend = 0; m_mask = 0; m_gen = 0; m_armed = 0;
      m_active = 0; m_vld = 0; m_phase = 0; m_src = 0; m_start = 0; m_dout = 0;
   endtask

   // One clock: predict from the current inputs, clock the DUT, compare outputs.
   task automatic step();
      int          off, win;
      bit [7:0]    rise, req;
      bit          eoi;
      logic [15:0] rd;
      off = int'(bus.bus_addr) - int'(BASE);
      case (off)
         0:       rd = {15'h0, m_gen};
         1:       rd = {8'h0, m_mask};
         2:       rd = {8'h0, m_pend};
         3:       rd = {m_active, 12'h0, 3'(m_src)};
         default: rd = 16'h0;
      endcase
      rise = m_armed ? (irq_src & ~m_prev) : 8'h0;
      req  = m_pend & m_mask;
      win  = -1;
      if (m_phase == 0 && m_gen && req != 0 && bus.int_rdy) begin
`ifdef YD_IRQ_RR_EN
         for (int k = 0; k < 8; k++)
            if (win < 0 && req[(m_start + k) % 8]) win = (m_start + k) % 8;
`else
         for (int k = 7; k >= 0; k--)
            if (req[k]) win = k;
`endif
      end
      eoi = bus.bus_we && off == 3 && m_phase == 2;
      if (bus.bus_we) begin
         case (off)
            0: m_gen  = bus.bus_din[0];
            1: m_mask = bus.bus_din[7:0];
            2: m_pend = m_pend & ~bus.bus_din[7:0];
            default: ;
         endcase
      end
      if (win >= 0) begin
         m_pend[win] = 1'b0;
         m_src       = win;
         m_active    = 1'b1;
         m_start     = (win + 1) % 8;
         m_phase     = 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (eoi) begin
         m_phase  = 0;
         m_active = 1'b0;
      end
      m_pend  = m_pend | rise;
      m_prev  = irq_src;
      m_armed = 1'b1;
      m_vld   = (m_phase == 1);
      m_dout  = rd;
      @(posedge clk);
      #1;
      $display("cyc addr=%h we=%0b din=%h rdy=%0b src=%h -> vld=%0b dout=%h",
               bus.bus_addr, bus.bus_we, bus.bus_din, bus.int_rdy, irq_src, bus.int_vld, bus.bus_dout);
      chk("int_vld", 16'(bus.int_vld), 16'(m_vld));
      chk("bus_dout", bus.bus_dout, m_dout);
   endtask

   task automatic wr(input int off, input logic [15:0] d);
      bus.bus_addr = BASE + 16'(off);
      bus.bus_din  = d;
      bus.bus_we   = 1'b1;
      step();
      bus.bus_we   = 1'b0;
      bus.bus_din  = 16'h0;
   endtask

   task automatic rd(input string tag, input int off, input logic [15:0] exp);
      bus.bus_addr = BASE + 16'(off);
      bus.bus_we   = 1'b0;
      step();
      chk(tag, bus.bus_dout, exp);
   endtask

   initial begin
      logic [15:0] first_id, second_id;
      int          sel;

`ifdef YD_IRQ_RR_EN
      first_id  = 16'h8006;
      second_id = 16'h8001;
`else
      first_id  = 16'h8001;
      second_id = 16'h8006;
`endif

      rst_n = 1'b0;
      irq_src = 8'h0;
      bus.bus_addr = 16'h0;
      bus.bus_din  = 16'h0;
      bus.bus_we   = 1'b0;
      bus.int_rdy  = 1'b1;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_vld", 16'(bus.int_vld), 16'h0);
      chk("reset_dout", bus.bus_dout, 16'h0);
      rst_n = 1'b1;

      rd("reset_ctrl", 0, 16'h0);
      rd("reset_mask", 1, 16'h0);
      rd("reset_pend", 2, 16'h0);
      rd("reset_id",   3, 16'h0);

      // Basic dispatch of source 2
      wr(0, 16'h0001);
      wr(1, 16'h0004);
      rd("ctrl_rb", 0, 16'h0001);
      bus.bus_addr = BASE + 16'd2;
      irq_src = 8'h04;
      step();
      irq_src = 8'h00;
      step();
      chk("basic_pend", bus.bus_dout, 16'h0004);
      chk("basic_vld", 16'(bus.int_vld), 16'h1);
      step();
      chk("basic_vld_pulse", 16'(bus.int_vld), 16'h0);
      rd("basic_id", 3, 16'h8002);
      rd("basic_pend_clr", 2, 16'h0);
      wr(3, 16'h0);

      // Masked source 5 stays pending until unmasked
      irq_src = 8'h20;
      step();
      irq_src = 8'h00;
      repeat (3) begin
         step();
         chk("masked_novld", 16'(bus.int_vld), 16'h0);
      end
      rd("masked_pend", 2, 16'h0020);
      wr(1, 16'h0020);
      step();
      chk("unmask_vld", 16'(bus.int_vld), 16'h1);
      rd("unmask_id", 3, 16'h8005);
      wr(3, 16'h0);

      // Sources 1 and 6 together, twice; the second pass starts with last ID = 1
      wr(1, 16'h00FF);
      for (int p = 0; p < 2; p++) begin
         irq_src = 8'h42;
         step();
         irq_src = 8'h00;
         step();
         chk("pair_first_vld", 16'(bus.int_vld), 16'h1);
         rd("pair_first_id", 3, first_id);
         wr(3, 16'h0);
         chk("pair_eoi_gap", 16'(bus.int_vld), 16'h0);
         step();
         chk("pair_second_vld", 16'(bus.int_vld), 16'h1);
         rd("pair_second_id", 3, second_id);
         wr(3, 16'h0);
      end

      // int_rdy low holds dispatch
      bus.int_rdy = 1'b0;
      irq_src = 8'h10;
      step();
      irq_src = 8'h00;
      repeat (10) begin
         step();
         chk("rdy_hold", 16'(bus.int_vld), 16'h0);
      end
      bus.int_rdy = 1'b1;
      step();
      chk("rdy_release", 16'(bus.int_vld), 16'h1);
      step();
      wr(3, 16'h0);

      // W1C and set on the same bit in the same cycle: set wins
      bus.int_rdy = 1'b0;
      irq_src = 8'h08;
      wr(2, 16'h0008);
      rd("set_wins", 2, 16'h0008);
      wr(2, 16'h0008);
      rd("w1c_clear", 2, 16'h0000);
      irq_src = 8'h00;

      // Out-of-window reads
      rd("oow_above", 4, 16'h0);
      bus.bus_addr = BASE - 16'd1;
      step();
      chk("oow_below", bus.bus_dout, 16'h0);

      // Asynchronous reset during SERVICE with source 0 held high across release
      bus.int_rdy = 1'b1;
      irq_src = 8'h01;
      step();
      step();
      chk("svc_vld", 16'(bus.int_vld), 16'h1);
      rd("svc_id", 3, 16'h8000);
      rst_n = 1'b0;
      #2;
      chk("async_rst_vld", 16'(bus.int_vld), 16'h0);
      chk("async_rst_dout", bus.bus_dout, 16'h0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wr(0, 16'h0001);
      wr(1, 16'h00FF);
      rd("rel_pend", 2, 16'h0);
      repeat (3) begin
         step();
         chk("rel_novld", 16'(bus.int_vld), 16'h0);
      end
      irq_src = 8'h00;
      step();
      irq_src = 8'h01;
      step();
      step();
      chk("rel_new_edge", 16'(bus.int_vld), 16'h1);
      step();
      wr(3, 16'h0);
      irq_src = 8'h00;

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ 8'($urandom);
         bus.int_rdy = ($urandom_range(0, 3) != 0);
         bus.bus_we  = 1'b0;
         bus.bus_din = 16'($urandom);
         sel = int'($urandom_range(0, 9));
         case (sel)
            0: begin
               bus.bus_addr   = BASE;
               bus.bus_we     = 1'b1;
               bus.bus_din[0] = ($urandom_range(0, 4) != 0);
            end
            1: begin
               bus.bus_addr = BASE + 16'd1;
               bus.bus_we   = 1'b1;
            end
            2: begin
               bus.bus_addr = BASE + 16'd2;
               bus.bus_we   = 1'b1;
               bus.bus_din  = 16'($urandom) & 16'($urandom);
            end
            3, 4: begin
               bus.bus_addr = BASE + 16'd3;
               bus.bus_we   = 1'b1;
            end
            9: bus.bus_addr = 16'($urandom);
            default: bus.bus_addr = BASE + 16'($urandom_range(0, 3));
         endcase
         step();
      end
      bus.bus_we = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/yd_irq_ctrl.md
YD_IRQ_CTRL -- requirements
Module: yd_irq_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00, 16-bit data-space base address of the 4-word register window.
REQ-002 Parameter NSRC, default 8, number of interrupt sources (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 irq_src  input  NSRC  level interrupt sources, active-high, synchronous to clk.
REQ-006 int_vld  output  1  to core; 1-cycle high pulse requesting interrupt entry.
REQ-007 int_rdy  input  1  from core; high = core can accept an interrupt.
REQ-008 bus_addr  input  16  data-bus address.
REQ-009 bus_din  input  16  data-bus write data.
REQ-010 bus_we  input  1  data-bus write enable, high = write.
REQ-011 bus_dout  output  16  register read data, valid the cycle after bus_addr is presented; 16'h0 when the address is outside the window.

Function
REQ-012 Register map, offsets from BASE_ADDR: +0 CTRL (bit0 GEN global enable, R/W); +1 MASK (bits NSRC-1:0, 1 = enabled, R/W); +2 PEND (R; write-1-to-clear); +3 ID (R: bit15 = active, bits 2:0 = source in service; any write = end-of-interrupt, EOI).
REQ-013 Unused register bits SHALL read 0 and ignore writes.
REQ-014 Each source SHALL be edge-detected against a 1-cycle registered copy; a 0->1 transition SHALL set its PEND bit.
REQ-015 When a PEND set and a PEND W1C hit the same bit in the same cycle, set SHALL win.
REQ-016 FSM states: IDLE, ISSUE, SERVICE.
REQ-017 IDLE->ISSUE when GEN=1, (PEND & MASK) != 0 and int_rdy=1; the winning source is selected in that cycle.
REQ-018 ISSUE lasts exactly one cycle: int_vld=1, ID.active=1, ID source latched, that source's PEND bit cleared; then go to SERVICE.
REQ-019 SERVICE: int_vld=0, no new dispatch; an ID write (EOI) returns to IDLE next cycle and clears ID.active.
REQ-020 Minimum EOI-to-next-int_vld latency: 2 cycles (EOI edge -> IDLE -> ISSUE).
REQ-021 int_rdy=0 in IDLE SHALL hold dispatch; pending bits are retained indefinitely.
REQ-022 Clearing GEN or a MASK bit SHALL not affect an interrupt already in ISSUE/SERVICE.
REQ-023 An EOI written outside SERVICE SHALL be ignored.
REQ-024 bus_dout SHALL be registered: the address is sampled at edge N and data is driven after edge N; a write and a read in the same cycle return the pre-write value.

Reset
REQ-025 rst_n low SHALL immediately force: FSM=IDLE, int_vld=0, bus_dout=0, CTRL=0, MASK=0, PEND=0, ID=0, edge registers=0.
REQ-026 After reset release, no edge is detected for a source that was already high at release.

Configuration
REQ-027 Macro YD_IRQ_RR_EN defined: round-robin selection; search starts at the source after the last dispatched ID (after reset, search starts at 0).
REQ-028 YD_IRQ_RR_EN undefined: fixed priority; the lowest-index enabled pending source wins.

Verification
REQ-029 Reset, then write CTRL=1 and MASK=8'h04, then pulse irq_src[2] -> PEND=8'h04 one cycle later; with int_rdy=1, one int_vld pulse follows; ID reads 16'h8002 and PEND reads 0.
REQ-030 irq_src[5] rises while MASK[5]=0 -> no int_vld; PEND[5]=1; then write MASK=8'h20 -> int_vld issues within 2 cycles.
REQ-031 Sources 1 and 6 rise together, MASK=8'hFF -> fixed priority: 1 then 6, with 6 issued only after EOI and at least 2 cycles later; RR_EN with last ID=1 and both pending again -> 6 first.
REQ-032 int_rdy=0 with an enabled pending source for 10 cycles -> int_vld stays 0; int_rdy rises -> int_vld is high the next cycle.
REQ-033 Write PEND W1C bit 3 in the same cycle as an irq_src[3] rising edge -> PEND[3] reads 1.
REQ-034 Assert rst_n low during SERVICE -> all outputs and registers read 0 asynchronously; no int_vld after release until a new edge occurs.
